// File: rtl/hex_debug_pager.sv
// hex_debug_pager: debug pager that shows one of NUM_CH internal buses on DIGITS 7-seg digits.
// The top digit shows the page index; the lower digits show the selected channel in hex.
// Two raw active-low keys are debounced: one steps the page, the other toggles a frozen
// snapshot of all channels.
// Optional feature macro: DEBUG_BLINK_EN (blink the index digit while frozen).
module hex_debug_pager #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CH_W         = 8,
   parameter int unsigned DIGITS       = 6,
   parameter int unsigned DEBOUNCE_CYC = 1000000,
   parameter int unsigned BLINK_DIV    = 12500000
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NUM_CH*CH_W-1:0]   ch_data,
   input  logic                     key_next_n,
   input  logic                     key_frz_n,
   output logic [DIGITS*7-1:0]      hex_out,
   output logic [3:0]               page,
   output logic                     frozen,
   output logic                     key_evt
);

   localparam int unsigned SrcW     = 4 * (DIGITS - 1);
   localparam int unsigned DbW      = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);
   localparam logic [3:0] PageLast  = 4'(NUM_CH - 1);
   localparam logic [6:0] Blank     = 7'h7F;

   // Reject parameter sets the display layout cannot represent.
   if (NUM_CH < 2 || NUM_CH > 16 || CH_W > SrcW || DEBOUNCE_CYC < 1 || BLINK_DIV < 1)
   begin : gen_param_err
      $error("hex_debug_pager: illegal parameter set");
   end

   // Active-low hex glyphs, bit0 = segment a.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return ~seg;
   endfunction

   // ---------------------------------------------------------------------------------------
   // Key debounce. Index 0 = next key, index 1 = freeze key. Levels are active-low, so a
   // released key reads 1 and every register starts at the released level.
   // ---------------------------------------------------------------------------------------
   logic [1:0]     raw_n;
   logic [1:0]     sync1_q, sync2_q;
   logic [1:0]     deb_q, deb_d, deb_prev_q;
   logic [DbW-1:0] cnt_q [2];
   logic [DbW-1:0] cnt_d [2];
   logic [1:0]     press;

   assign raw_n = {key_frz_n, key_next_n};

   // Next debounced level: count while sync and debounced differ, accept on the last count.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         deb_d[k] = deb_q[k];
         cnt_d[k] = '0;
         if (sync2_q[k] != deb_q[k]) begin
            if (cnt_q[k] == DbLast) begin
               deb_d[k] = sync2_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // A press is the cycle right after the debounced level falls; releases are silent.
   assign press = deb_prev_q & ~deb_q;

   // Synchroniser, debounce counters and debounced key levels.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_q    <= 2'b11;
         sync2_q    <= 2'b11;
         deb_q      <= 2'b11;
         deb_prev_q <= 2'b11;
         cnt_q[0]   <= '0;
         cnt_q[1]   <= '0;
      end else begin
         sync1_q    <= raw_n;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         cnt_q[0]   <= cnt_d[0];
         cnt_q[1]   <= cnt_d[1];
      end
   end

   // ---------------------------------------------------------------------------------------
   // Page, freeze and snapshot state.
   // ---------------------------------------------------------------------------------------
   logic [3:0]      page_q;
   logic            frozen_q;
   logic            key_evt_q;
   logic [CH_W-1:0] snap_q [NUM_CH];

   // Apply press events; a freeze-on captures every channel from the live bus on that edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         page_q    <= '0;
         frozen_q  <= 1'b0;
         key_evt_q <= 1'b0;
         for (int c = 0; c < int'(NUM_CH); c++) begin
            snap_q[c] <= '0;
         end
      end else begin
         key_evt_q <= |press;
         if (press[0]) begin
            page_q <= (page_q == PageLast) ? 4'h0 : page_q + 4'h1;
         end
         if (press[1]) begin
            frozen_q <= ~frozen_q;
         end
         if (press[1] && !frozen_q) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
               snap_q[c] <= ch_data[c*CH_W +: CH_W];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Optional blink of the index digit while frozen.
   // ---------------------------------------------------------------------------------------
   logic idx_blank;

`ifdef DEBUG_BLINK_EN
   localparam int unsigned BlW = $clog2(BLINK_DIV + 1);
   localparam logic [BlW-1:0] BlLast = BlW'(BLINK_DIV - 1);

   logic [BlW-1:0] blink_cnt_q;
   logic           blink_on_q;

   // Phase generator, parked in the on phase whenever the display is live.
   always_ff @(posedge clk) begin
      if (!resetn || !frozen_q) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (blink_cnt_q == BlLast) begin
         blink_cnt_q <= '0;
         blink_on_q  <= ~blink_on_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end

   assign idx_blank = frozen_q & ~blink_on_q;
`else
   assign idx_blank = 1'b0;
`endif

   // ---------------------------------------------------------------------------------------
   // Display path.
   // ---------------------------------------------------------------------------------------
   logic [CH_W-1:0]       sel;
   logic [SrcW-1:0]       src;
   logic [DIGITS*7-1:0]   hex_d;
   logic [DIGITS*7-1:0]   hex_q;

   // Select the paged channel (live or snapshot) and decode it into digit glyphs.
   always_comb begin
      sel = '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (page_q == 4'(c)) begin
            sel = frozen_q ? snap_q[c] : ch_data[c*CH_W +: CH_W];
         end
      end
      src   = SrcW'(sel);
      hex_d = '1;
      for (int d = 0; d < int'(DIGITS) - 1; d++) begin
         hex_d[d*7 +: 7] = hex7(src[d*4 +: 4]);
      end
      hex_d[(DIGITS-1)*7 +: 7] = idx_blank ? Blank : hex7(page_q);
   end

   // Registered segment outputs, blank during reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hex_q <= '1;
      end else begin
         hex_q <= hex_d;
      end
   end

   assign hex_out = hex_q;
   assign page    = page_q;
   assign frozen  = frozen_q;
   assign key_evt = key_evt_q;

endmodule

// File: tb/tb_hex_debug_pager.sv
// Directed bench for hex_debug_pager with small debounce/blink constants.
module tb_hex_debug_pager;

   localparam int unsigned NumCh  = 4;
   localparam int unsigned ChW    = 8;
   localparam int unsigned Digits = 6;

   logic                   clk = 1'b0;
   logic                   resetn;
   logic [NumCh*ChW-1:0]   ch_data;
   logic                   key_next_n;
   logic                   key_frz_n;
   logic [Digits*7-1:0]    hex_out;
   logic [3:0]             page;
   logic                   frozen;
   logic                   key_evt;

   hex_debug_pager #(
      .NUM_CH      (NumCh),
      .CH_W        (ChW),
      .DIGITS      (Digits),
      .DEBOUNCE_CYC(4),
      .BLINK_DIV   (8)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .ch_data   (ch_data),
      .key_next_n(key_next_n),
      .key_frz_n (key_frz_n),
      .hex_out   (hex_out),
      .page      (page),
      .frozen    (frozen),
      .key_evt   (key_evt)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      string       tag;
      logic [41:0] hex;
      bit          frz;
   } exp_t;
   exp_t sb[$];

   localparam logic [41:0] IdxMask = {7'h7F, 35'b0};

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Digits 4..2 always show 0 because channels are 8 bits wide.
   function automatic logic [41:0] disp(input logic [7:0] v, input logic [3:0] pg);
      return {glyph(pg), glyph(4'h0), glyph(4'h0), glyph(4'h0), glyph(v[7:4]), glyph(v[3:0])};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input string tag, input logic [7:0] v, input logic [3:0] pg,
                       input bit frz);
      exp_t e;
      e.tag = tag;
      e.hex = disp(v, pg);
      e.frz = frz;
      sb.push_back(e);
   endtask

   // Compare every queued display expectation against the current segment outputs.
   task automatic pop_check();
      exp_t        e;
      logic [41:0] m;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         m = '0;
`ifdef DEBUG_BLINK_EN
         if (e.frz) m = IdxMask;
`endif
         chk(e.tag, 64'(hex_out | m), 64'(e.hex | m));
      end
   endtask

   // Press the selected keys cleanly, expecting exactly one key_evt; report state at the strobe.
   task automatic press(input string tag, input bit nxt, input bit frz,
                        output int first, output logic [3:0] evt_page, output logic evt_frz);
      int cnt = 0;
      first    = -1;
      evt_page = 'x;
      evt_frz  = 'x;
      if (nxt) key_next_n = 1'b0;
      if (frz) key_frz_n  = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         step(1);
         if (key_evt === 1'b1) begin
            cnt++;
            if (first < 0) begin
               first    = i;
               evt_page = page;
               evt_frz  = frozen;
            end
         end
      end
      key_next_n = 1'b1;
      key_frz_n  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (key_evt === 1'b1) cnt++;
      end
      chk({tag, "_evt_count"}, 64'(cnt), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         first;
      int         cnt;
      logic [3:0] ep;
      logic       ef;
      logic [3:0] exp_page;

      resetn     = 1'b0;
      key_next_n = 1'b1;
      key_frz_n  = 1'b1;
      ch_data    = {8'h96, 8'hA5, 8'h21, 8'h3C};

      // 1: reset state and first display
      step(2);
      chk("rst_hex", 64'(hex_out), 64'(42'h3FF_FFFF_FFFF));
      chk("rst_page", 64'(page), 64'd0);
      chk("rst_frozen", 64'(frozen), 64'd0);
      chk("rst_key_evt", 64'(key_evt), 64'd0);
      resetn = 1'b1;
      push("first_disp", 8'h3C, 4'h0, 1'b0);
      step(1);
      pop_check();

      // 2: short glitch is rejected, long press fires once at the 7th edge
      key_next_n = 1'b0;
      step(3);
      key_next_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (key_evt === 1'b1) cnt++;
      end
      chk("glitch_evt", 64'(cnt), 64'd0);
      chk("glitch_page", 64'(page), 64'd0);
      press("long", 1'b1, 1'b0, first, ep, ef);
      chk("long_latency", 64'(first), 64'd7);
      chk("long_page", 64'(page), 64'd1);
      chk("long_evt_page", 64'(ep), 64'd1);

      // 3: page stepping and wrap
      exp_page = 4'd1;
      for (int i = 0; i < 7; i++) begin
         press("wrap", 1'b1, 1'b0, first, ep, ef);
         exp_page = (exp_page == 4'd3) ? 4'd0 : exp_page + 4'd1;
         chk($sformatf("wrap_page%0d", i), 64'(page), 64'(exp_page));
      end

      // 4: freeze, snapshot retention, paging while frozen, unfreeze
      press("to_p1", 1'b1, 1'b0, first, ep, ef);
      press("to_p2", 1'b1, 1'b0, first, ep, ef);
      chk("frz_pre_page", 64'(page), 64'd2);
      push("live_p2", 8'hA5, 4'h2, 1'b0);
      pop_check();
      press("frz_on", 1'b0, 1'b1, first, ep, ef);
      chk("frz_on_state", 64'(frozen), 64'd1);
      ch_data[2*ChW +: ChW] = 8'h11;
      ch_data[3*ChW +: ChW] = 8'h77;
      push("snap_p2", 8'hA5, 4'h2, 1'b1);
      step(2);
      pop_check();
      press("frz_next", 1'b1, 1'b0, first, ep, ef);
      chk("frz_next_page", 64'(page), 64'd3);
      push("snap_p3", 8'h96, 4'h3, 1'b1);
      pop_check();
      press("frz_off", 1'b0, 1'b1, first, ep, ef);
      chk("frz_off_state", 64'(frozen), 64'd0);
      push("live_p3", 8'h77, 4'h3, 1'b0);
      pop_check();

      // 5: simultaneous presses land on the same edge with a single strobe
      press("simul", 1'b1, 1'b1, first, ep, ef);
      chk("simul_latency", 64'(first), 64'd7);
      chk("simul_page", 64'(ep), 64'd0);
      chk("simul_frozen", 64'(ef), 64'd1);
      ch_data[0*ChW +: ChW] = 8'h44;
      push("simul_snap", 8'h3C, 4'h0, 1'b1);
      step(2);
      pop_check();

`ifdef DEBUG_BLINK_EN
      // Frozen index digit toggles blank every 8 cycles
      begin
         int   t[$];
         logic prev_b;
         logic cur_b;
         prev_b = (hex_out[41:35] == 7'h7F);
         for (int i = 0; i < 40; i++) begin
            step(1);
            cur_b = (hex_out[41:35] == 7'h7F);
            if (cur_b != prev_b) t.push_back(i);
            prev_b = cur_b;
         end
         chk("blink_toggles", 64'(t.size() >= 4), 64'd1);
         for (int i = 1; i < t.size(); i++) begin
            chk($sformatf("blink_gap%0d", i), 64'(t[i] - t[i-1]), 64'd8);
         end
      end
`endif

      // 6: reset while frozen
      resetn = 1'b0;
      step(1);
      chk("rst2_frozen", 64'(frozen), 64'd0);
      chk("rst2_page", 64'(page), 64'd0);
      chk("rst2_hex", 64'(hex_out), 64'(42'h3FF_FFFF_FFFF));
      resetn = 1'b1;
      push("rst2_disp", 8'h44, 4'h0, 1'b0);
      step(1);
      pop_check();

`ifdef DEBUG_BLINK_EN
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (hex_out[41:35] == 7'h7F) cnt++;
      end
      chk("unfrozen_no_blink", 64'(cnt), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
